// File: rtl/tangram_ctrl_pkg.sv
// Shared types for the tangram piece controls: stepper FSM states and step direction.
// Supplies a fallback INT_BITS when the math constants header has not been included.
`ifndef INT_BITS
`define INT_BITS 16
`endif

package tangram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } angle_step_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } step_dir_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/circular_step.sv
// Wrap-around +1/-1 neighbours of a signed value inside [DW_BOUND, UP_BOUND].
module circular_step #(
  parameter int DATAW    = 16,
  parameter int DW_BOUND = -180,
  parameter int UP_BOUND = 179
) (
  input  logic signed [DATAW-1:0] in,
  output logic signed [DATAW-1:0] prev,
  output logic signed [DATAW-1:0] next
);

  localparam logic signed [DATAW-1:0] DW_V = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] UP_V = DATAW'(UP_BOUND);
  localparam logic signed [DATAW-1:0] ONE  = DATAW'(1);

  // neighbours with wrap at either bound
  always_comb begin
    next = in + ONE;
    prev = in - ONE;
    if (in >= UP_V) begin
      next = DW_V;
    end else begin
      next = in + ONE;
    end
    if (in <= DW_V) begin
      prev = UP_V;
    end else begin
      prev = in - ONE;
    end
  end

endmodule

// File: rtl/angle_stepper.sv
// Rotation angle of the selected piece, stepped one degree per button press.
// Define ANGLE_STEPPER_REPEAT_EN to enable hold-to-repeat (DELAY/REPEAT states and counter).
module angle_stepper
  import tangram_ctrl_pkg::*;
#(
  parameter int DATAW         = `INT_BITS,
  parameter int DW_BOUND      = -180,
  parameter int UP_BOUND      = 179,
  parameter int RESET_VALUE   = 0,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    inc_btn,
  input  logic                    dec_btn,
  input  logic                    load,
  input  logic signed [DATAW-1:0] load_value,
  output logic signed [DATAW-1:0] angle,
  output logic                    changed
);

  localparam logic signed [DATAW-1:0] DW_V    = DATAW'(DW_BOUND);
  localparam logic signed [DATAW-1:0] UP_V    = DATAW'(UP_BOUND);
  localparam logic signed [DATAW-1:0] RESET_V = DATAW'(RESET_VALUE);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      RESET_VALUE < DW_BOUND || RESET_VALUE > UP_BOUND) begin : g_bad_cfg
    $error("angle_stepper: illegal parameter combination");
  end

  logic                    inc_q_r;
  logic                    dec_q_r;
  logic                    press_inc_s;
  logic                    press_dec_s;
  logic                    load_ok_s;
  logic                    step_s;
  step_dir_e               step_dir_s;
  logic signed [DATAW-1:0] prev_s;
  logic signed [DATAW-1:0] next_s;

  circular_step #(
    .DATAW   (DATAW),
    .DW_BOUND(DW_BOUND),
    .UP_BOUND(UP_BOUND)
  ) u_circular_step (
    .in  (angle),
    .prev(prev_s),
    .next(next_s)
  );

  // previous button levels; reset high so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q_r <= 1'b1;
      dec_q_r <= 1'b1;
    end else begin
      inc_q_r <= inc_btn;
      dec_q_r <= dec_btn;
    end
  end

  assign press_inc_s = en & inc_btn & ~inc_q_r & ~dec_btn;
  assign press_dec_s = en & dec_btn & ~dec_q_r & ~inc_btn;
  assign load_ok_s   = load & (load_value >= DW_V) & (load_value <= UP_V);

`ifdef ANGLE_STEPPER_REPEAT_EN
  localparam int              CNT_MAX   = max_int(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int              CNTW      = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPEAT_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_SAT   = CNTW'(CNT_MAX);

  angle_step_state_e state_r;
  angle_step_state_e state_s;
  step_dir_e         dir_r;
  logic [CNTW-1:0]   cnt_r;
  logic              cnt_clr_s;
  logic              held_s;

  assign held_s = en & ((dir_r == DIR_INC) ? (inc_btn & ~dec_btn) : (dec_btn & ~inc_btn));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // latched direction and saturating hold/repeat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r <= DIR_INC;
      cnt_r <= {CNTW{1'b0}};
    end else begin
      if (state_r == IDLE && (press_inc_s || press_dec_s)) begin
        dir_r <= press_inc_s ? DIR_INC : DIR_DEC;
      end
      if (cnt_clr_s) begin
        cnt_r <= {CNTW{1'b0}};
      end else if (cnt_r != CNT_SAT) begin
        cnt_r <= cnt_r + CNTW'(1);
      end
    end
  end

  // next-state logic; a valid load always returns to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!load_ok_s && (press_inc_s || press_dec_s)) begin
          state_s = DELAY;
        end else begin
          state_s = IDLE;
        end
      end
      DELAY: begin
        if (load_ok_s || !held_s) begin
          state_s = IDLE;
        end else if (cnt_r >= HOLD_LAST) begin
          state_s = REPEAT;
        end else begin
          state_s = DELAY;
        end
      end
      REPEAT: begin
        if (load_ok_s || !held_s) begin
          state_s = IDLE;
        end else begin
          state_s = REPEAT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // step request and counter clear
  always_comb begin
    step_s     = 1'b0;
    step_dir_s = dir_r;
    cnt_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!load_ok_s && (press_inc_s || press_dec_s)) begin
          step_s     = 1'b1;
          step_dir_s = press_inc_s ? DIR_INC : DIR_DEC;
          cnt_clr_s  = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      DELAY: begin
        if (!load_ok_s && held_s && cnt_r >= HOLD_LAST) begin
          step_s    = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      REPEAT: begin
        if (!load_ok_s && held_s && cnt_r >= REP_LAST) begin
          step_s    = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      default: begin
        step_s    = 1'b0;
        cnt_clr_s = 1'b1;
      end
    endcase
  end
`else
  // one step per press
  always_comb begin
    step_s     = 1'b0;
    step_dir_s = DIR_INC;
    if (press_inc_s || press_dec_s) begin
      step_s     = 1'b1;
      step_dir_s = press_inc_s ? DIR_INC : DIR_DEC;
    end else begin
      step_s = 1'b0;
    end
  end
`endif

  // angle register and change pulse; load wins over a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle   <= RESET_V;
      changed <= 1'b0;
    end else if (load_ok_s) begin
      angle   <= load_value;
      changed <= 1'b1;
    end else if (step_s) begin
      angle   <= (step_dir_s == DIR_INC) ? next_s : prev_s;
      changed <= 1'b1;
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_angle_stepper.sv
// Scoreboard bench for angle_stepper: stimulus queues expected (angle, edge) pairs,
// a negedge monitor checks every changed pulse against them.
module tb_angle_stepper;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               inc_btn;
  logic               dec_btn;
  logic               load;
  logic signed [15:0] load_value;
  logic signed [15:0] angle;
  logic               changed;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cur;
  int   base;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  angle_stepper #(
    .DATAW        (16),
    .DW_BOUND     (-180),
    .UP_BOUND     (179),
    .RESET_VALUE  (0),
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn),
    .load      (load),
    .load_value(load_value),
    .angle     (angle),
    .changed   (changed)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  // monitor: every changed pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && changed) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: angle=%0d at cycle %0d, expected no change", angle, cyc);
      end else begin
        e = sbq.pop_front();
        check("angle_value", int'(angle), e.val);
        check("step_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; inc_btn = 1'b1; dec_btn = 1'b0;
    load = 1'b0; load_value = 16'sd0;
    tick(3);
    check("reset_angle", int'(angle), 0);
    check("reset_changed", int'(changed), 0);
    rst_n = 1'b1;
    tick(10);
    check("held_through_reset", int'(angle), 0);
    inc_btn = 1'b0;
    tick(2);

    // wrap 179 -> -180 -> 179
    load = 1'b1; load_value = 16'sd179; expect_at(179, cyc + 1);
    tick(1);
    load = 1'b0;
    tick(2);
    inc_btn = 1'b1; expect_at(-180, cyc + 1);
    tick(1);
    inc_btn = 1'b0;
    tick(3);
    check("wrap_up", int'(angle), -180);
    dec_btn = 1'b1; expect_at(179, cyc + 1);
    tick(1);
    dec_btn = 1'b0;
    tick(3);
    check("wrap_down", int'(angle), 179);

    // hold-to-repeat from 0
    load = 1'b1; load_value = 16'sd0; expect_at(0, cyc + 1);
    tick(1);
    load = 1'b0;
    tick(5);
    inc_btn = 1'b1; base = cyc + 1;
    expect_at(1, base);
`ifdef ANGLE_STEPPER_REPEAT_EN
    expect_at(2, base + 4);
    expect_at(3, base + 6);
    expect_at(4, base + 8);
    expect_at(5, base + 10);
    cur = 5;
`else
    cur = 1;
`endif
    tick(12);
    inc_btn = 1'b0;
    tick(8);
    check("hold_repeat", int'(angle), cur);

    // both rising together, then opposite button during DELAY
    inc_btn = 1'b1; dec_btn = 1'b1;
    tick(8);
    inc_btn = 1'b0; dec_btn = 1'b0;
    tick(2);
    check("both_rise", int'(angle), cur);
    inc_btn = 1'b1; expect_at(cur + 1, cyc + 1); cur = cur + 1;
    tick(2);
    dec_btn = 1'b1;
    tick(8);
    inc_btn = 1'b0; dec_btn = 1'b0;
    tick(2);
    check("conflict_in_delay", int'(angle), cur);

    // load priority and range
    load = 1'b1; load_value = 16'sd90; inc_btn = 1'b1; expect_at(90, cyc + 1);
    tick(1);
    load = 1'b0;
    tick(1);
    inc_btn = 1'b0;
    tick(3);
    check("load_priority", int'(angle), 90);
    load = 1'b1; load_value = 16'sd200;
    tick(1);
    load_value = -16'sd181;
    tick(1);
    load = 1'b0;
    tick(3);
    check("load_out_of_range", int'(angle), 90);
    load = 1'b1; load_value = -16'sd180; expect_at(-180, cyc + 1);
    tick(1);
    load = 1'b0;
    tick(2);
    check("load_low_bound", int'(angle), -180);

    // en gating: load still works, buttons do not
    en = 1'b0;
    load = 1'b1; load_value = 16'sd45; expect_at(45, cyc + 1);
    tick(1);
    load = 1'b0;
    tick(1);
    inc_btn = 1'b1;
    tick(8);
    inc_btn = 1'b0;
    tick(2);
    check("en_gating", int'(angle), 45);
    en = 1'b1;

    // reset in the middle of a hold
    inc_btn = 1'b1; expect_at(46, cyc + 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midhold_reset_angle", int'(angle), 0);
    check("midhold_reset_changed", int'(changed), 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("held_after_reset", int'(angle), 0);
    inc_btn = 1'b0;
    tick(3);

    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
